// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bundle for the memory access controller.
// The MEM stage drives requests through 'master'; the controller answers through 'slave'.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Converts byte/half/word loads and stores into word accesses on the data memory,
// using read-modify-write for sub-word stores and blocking misaligned accesses.
module mem_access_ctrl #(
   parameter bit MISALIGN_ERR = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_ctrl_if.slave   bus,
   output logic [31:0]        dm_addr,
   output logic               dm_re,
   output logic               dm_we,
   output logic [31:0]        dm_wdata,
   input  logic [31:0]        dm_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic        we_q;
   logic        err_q;

   logic        req_err;
   logic [31:0] req_addr_al;
   logic [1:0]  off;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign off = addr_q[1:0];

   // Classify the incoming request; with errors disabled, misaligned half/word
   // accesses are rounded down to their natural boundary instead of rejected.
   always_comb begin
      req_err     = 1'b0;
      req_addr_al = bus.req_addr;
      case (bus.req_size)
         2'b01: begin
            if (bus.req_addr[0]) begin
               if (MISALIGN_ERR) req_err = 1'b1;
               else              req_addr_al[0] = 1'b0;
            end
         end
         2'b10: begin
            if (bus.req_addr[1:0] != 2'b00) begin
               if (MISALIGN_ERR) req_err = 1'b1;
               else              req_addr_al[1:0] = 2'b00;
            end
         end
         2'b11:   req_err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Word stores skip the read phase; everything else that is legal reads first.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_err)                                  state_next = RESP;
               else if (bus.req_we && bus.req_size == 2'b10) state_next = WR;
               else                                          state_next = RD;
            end
         end
         RD:      state_next = we_q ? WR : RESP;
         WR:      state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      lane_b = dm_rdata[{off, 3'b000} +: 8];
      lane_h = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
         2'b01:   load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
         default: load_ext = dm_rdata;
      endcase
   end

   // Only the addressed lane of the previously read word is replaced.
   always_comb begin
      merged = merge_q;
      case (size_q)
         2'b00: merged[{off, 3'b000} +: 8] = wdata_q[7:0];
         2'b01: begin
            if (off[1]) merged[31:16] = wdata_q[15:0];
            else        merged[15:0]  = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   // Load data is cleared on every accept so stores and errors return zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            addr_q  <= req_addr_al;
            size_q  <= bus.req_size;
            sign_q  <= bus.req_sign;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
         end
         if (state == RD) begin
            merge_q <= dm_rdata;
            if (!we_q) rdata_q <= load_ext;
         end
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_err   = (state == RESP) && err_q;
   assign bus.rsp_rdata = rdata_q;

   assign dm_re    = (state == RD);
   assign dm_we    = (state == WR) && !reset;
   assign dm_addr  = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
   assign dm_wdata = (state == WR) ? merged : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random traffic
// compared against a word-array reference model of the memory semantics.
module tb_mem_access_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] dm_addr;
   logic        dm_re;
   logic        dm_we;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;

   mem_access_ctrl_if bus();

   mem_access_ctrl #(.MISALIGN_ERR(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .dm_addr  (dm_addr),
      .dm_re    (dm_re),
      .dm_we    (dm_we),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] dmMem  [64];
   logic [31:0] refMem [64];
   logic        loadEn;
   logic [5:0]  loadIdx;
   logic [31:0] loadData;

   // Data memory: combinational read, written on the clock edge; loadEn preloads it.
   assign dm_rdata = dmMem[dm_addr[7:2]];
   always @(posedge clk) begin
      if (dm_we)       dmMem[dm_addr[7:2]] <= dm_wdata;
      else if (loadEn) dmMem[loadIdx]      <= loadData;
   end

   int          checks;
   int          failures;
   int          lastLat;
   int          lastReCnt;
   int          lastWeCnt;
   logic [31:0] lastRdata;
   logic        lastErr;
   logic [31:0] lastReAddr;
   logic [31:0] lastWeAddr;
   logic [31:0] lastWeData;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference semantics: plain shift/mask arithmetic on a word array.
   task automatic modelTxn(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] expRdata, output logic expErr,
                           output int expLat, output int expRe, output int expWe,
                           output logic [31:0] expWord);
      int          sh;
      logic [31:0] w;
      logic [31:0] v;
      logic [31:0] mask;
      expErr   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      sh       = 8 * int'(a[1:0]);
      w        = refMem[a[7:2]];
      expRdata = 32'h0;
      expWord  = w;
      expRe    = 0;
      expWe    = 0;
      if (expErr) begin
         expLat = 1;
      end else if (!we) begin
         expLat = 2;
         expRe  = 1;
         if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
         end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
         end else begin
            v = w;
         end
         expRdata = v;
      end else begin
         expWe = 1;
         if (sz == 2'd2) begin
            expLat  = 2;
            expWord = wd;
         end else begin
            expLat  = 3;
            expRe   = 1;
            mask    = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            expWord = (w & ~mask) | ((wd << sh) & mask);
         end
         refMem[a[7:2]] = expWord;
      end
   endtask

   // Called at a falling edge with the DUT idle; returns at the response cycle.
   task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input bit holdValid);
      logic [31:0] expRdata;
      logic [31:0] expWord;
      logic        expErr;
      int          expLat;
      int          expRe;
      int          expWe;
      modelTxn(we, sz, sg, a, wd, expRdata, expErr, expLat, expRe, expWe, expWord);
      bus.req_we    = we;
      bus.req_size  = sz;
      bus.req_sign  = sg;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      checkOutput("req_ready_idle", 32'(bus.req_ready), 32'h1);
      lastLat    = 0;
      lastReCnt  = 0;
      lastWeCnt  = 0;
      lastReAddr = 32'h0;
      lastWeAddr = 32'h0;
      lastWeData = 32'h0;
      @(posedge clk);
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) checkOutput("req_ready_busy", 32'(bus.req_ready), 32'h0);
         if (dm_re) begin
            lastReCnt++;
            lastReAddr = dm_addr;
         end
         if (dm_we) begin
            lastWeCnt++;
            lastWeAddr = dm_addr;
            lastWeData = dm_wdata;
         end
         if (bus.rsp_valid) begin
            lastLat   = cyc;
            lastRdata = bus.rsp_rdata;
            lastErr   = bus.rsp_err;
            break;
         end
      end
      if (!holdValid) bus.req_valid = 1'b0;
      checkOutput("latency", 32'(lastLat), 32'(expLat));
      checkOutput("rsp_rdata", lastRdata, expRdata);
      checkOutput("rsp_err", 32'(lastErr), 32'(expErr));
      checkOutput("dm_re_cycles", 32'(lastReCnt), 32'(expRe));
      checkOutput("dm_we_cycles", 32'(lastWeCnt), 32'(expWe));
      if (expRe != 0) checkOutput("dm_addr_rd", lastReAddr, {a[31:2], 2'b00});
      if (expWe != 0) begin
         checkOutput("dm_addr_wr", lastWeAddr, {a[31:2], 2'b00});
         checkOutput("dm_wdata", lastWeData, expWord);
      end
      checkOutput("mem_word", dmMem[a[7:2]], refMem[a[7:2]]);
   endtask

   logic seenWe;
   logic seenRsp;

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      loadEn        = 1'b0;
      loadIdx       = '0;
      loadData      = '0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'b00;
      bus.req_sign  = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;

      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         loadIdx    = 6'(i);
         loadData   = (i == 4) ? 32'h8899AABB : $urandom;
         refMem[i]  = loadData;
         loadEn     = 1'b1;
      end
      @(negedge clk);
      loadEn = 1'b0;

      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
      checkOutput("rst_dm_re", 32'(dm_re), 32'h0);
      checkOutput("rst_dm_we", 32'(dm_we), 32'h0);
      checkOutput("rst_dm_wdata", dm_wdata, 32'h0);
      checkOutput("rst_dm_addr", dm_addr, 32'h0);
      reset = 1'b0;

      $display("[TB] directed loads on word 0x10");
      @(negedge clk); applyStimulus(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);
      checkOutput("ldb_signed", lastRdata, 32'hFFFFFFAA);
      @(negedge clk); applyStimulus(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
      checkOutput("ldb_unsigned", lastRdata, 32'h000000AA);
      @(negedge clk); applyStimulus(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
      checkOutput("ldh_signed", lastRdata, 32'hFFFF8899);
      @(negedge clk); applyStimulus(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0);
      checkOutput("ldw", lastRdata, 32'h8899AABB);

      // Load data must persist through idle cycles with req_valid low.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
         checkOutput("idle_dm_act", {30'h0, dm_re, dm_we}, 32'h0);
         checkOutput("idle_rdata_hold", bus.rsp_rdata, 32'h8899AABB);
      end

      $display("[TB] sub-word store and error cases");
      @(negedge clk); applyStimulus(1'b1, 2'd0, 1'b0, 32'h12, 32'h123456CC, 1'b0);
      checkOutput("stb_wdata", lastWeData, 32'h88CCAABB);
      checkOutput("stb_addr", lastWeAddr, 32'h10);
      checkOutput("stb_lat", 32'(lastLat), 32'd3);
      @(negedge clk); applyStimulus(1'b1, 2'd1, 1'b0, 32'h13, 32'h00005555, 1'b0);
      checkOutput("mis_err", 32'(lastErr), 32'h1);
      checkOutput("mis_lat", 32'(lastLat), 32'd1);
      checkOutput("mis_mem", dmMem[4], 32'h88CCAABB);
      @(negedge clk); applyStimulus(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0);
      checkOutput("ill_err", 32'(lastErr), 32'h1);
      checkOutput("ill_rdata", lastRdata, 32'h0);
      checkOutput("ill_mem", dmMem[4], 32'h88CCAABB);

      $display("[TB] reset during read phase of a sub-word store");
      @(negedge clk);
      bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_sign = 1'b0;
      bus.req_addr = 32'h15; bus.req_wdata = 32'h000000EE; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstrd_dm_re", 32'(dm_re), 32'h1);
      reset = 1'b1; bus.req_valid = 1'b0;
      #1 checkOutput("rstrd_dm_we", 32'(dm_we), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rstrd_ready", 32'(bus.req_ready), 32'h1);
      seenWe = 1'b0; seenRsp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (dm_we) seenWe = 1'b1;
         if (bus.rsp_valid) seenRsp = 1'b1;
      end
      checkOutput("rstrd_no_we", 32'(seenWe), 32'h0);
      checkOutput("rstrd_no_rsp", 32'(seenRsp), 32'h0);
      checkOutput("rstrd_mem", dmMem[5], refMem[5]);

      $display("[TB] reset during write phase of a sub-word store");
      @(negedge clk);
      bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstwr_pre_we", 32'(dm_we), 32'h1);
      reset = 1'b1; bus.req_valid = 1'b0;
      #1 checkOutput("rstwr_dm_we", 32'(dm_we), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rstwr_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("rstwr_rsp", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rstwr_mem", dmMem[5], refMem[5]);
      @(negedge clk); applyStimulus(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);

      $display("[TB] back-to-back store then load with req_valid held");
      @(negedge clk); applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1);
      bus.req_we = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'h0;
      @(negedge clk);
      checkOutput("b2b_ready", 32'(bus.req_ready), 32'h1);
      checkOutput("b2b_no_re", 32'(dm_re), 32'h0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
      checkOutput("b2b_rdata", lastRdata, 32'hDEADBEEF);

      $display("[TB] random traffic");
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                       $urandom, 1'b0);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
